// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule engine.
// Takes a 128-bit cipher key, computes one round key per clock and stores all
// ROUNDS+1 round keys in a local buffer. The buffer has a registered read port
// with 1-cycle latency.
//
// Handshake: start is a request that is taken only while idle (busy=0). Once
// taken, the key is captured and busy stays high until the last round key is
// written. At that edge busy drops, done pulses for one cycle and keys_valid
// rises. A start in the done cycle is taken because the engine is already idle.
//
// Optional build macro: KEY_EXPAND_ZEROIZE_EN adds a zeroize input. When
// zeroize is high it clears the buffer and all expansion state, and it wins
// over start.
//
// The module aes_sbox (combinational AES S-box) is also in this file.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   // GF(2^8) multiply, reduced by the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] b;
      acc = 8'h00;
      b   = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ b;
         b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254. The result for 0 is 0, which the S-box
   // definition needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = gf_mul(x, x);
      r = p;
      for (int i = 0; i < 6; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   logic [7:0] inv;

   // Inverse followed by the affine transform.
   always_comb begin
      inv = gf_inv(a);
      s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_key_expand #(
   parameter int ROUNDS = 10,  // only 10 (AES-128) is meaningful
   parameter int IDX_W  = 4    // must be >= $clog2(ROUNDS+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [127:0]       key,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               keys_valid,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [127:0]       rd_key
`ifdef KEY_EXPAND_ZEROIZE_EN
   ,
   input  logic               zeroize
`endif
);

   localparam int               NKEYS    = ROUNDS + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // state is the probe point for FSM checkers.
   state_t             state;
   logic [127:0]       prev;
   logic [7:0]         rcon;
   logic [IDX_W-1:0]   cnt;
   logic [127:0]       key_buf [NKEYS];

   logic [31:0]        rot_word;
   logic [31:0]        sub_word;
   logic [31:0]        t_word;
   logic [127:0]       next_key;
   logic [7:0]         rcon_next;

   // RotWord on p3: rotate left by one byte.
   assign rot_word = {prev[23:0], prev[31:24]};

   // SubWord: one S-box per byte.
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .a (rot_word[g*8 +: 8]),
         .s (sub_word[g*8 +: 8])
      );
   end

   // Round function. p0 is the top word of prev and p3 is the bottom word.
   always_comb begin
      t_word          = sub_word ^ {rcon, 24'h000000};
      next_key        = '0;
      next_key[127:96] = prev[127:96] ^ t_word;
      next_key[95:64]  = prev[95:64]  ^ next_key[127:96];
      next_key[63:32]  = prev[63:32]  ^ next_key[95:64];
      next_key[31:0]   = prev[31:0]   ^ next_key[63:32];
      rcon_next       = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
   end

   // Expansion FSM, round-key buffer and registered read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         prev       <= '0;
         rcon       <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         rd_key     <= '0;
         for (int i = 0; i < NKEYS; i++) key_buf[i] <= '0;
      end else begin
         done   <= 1'b0;
         // The read sees the buffer before this edge's write (read-old).
         rd_key <= (rd_idx <= LAST_IDX) ? key_buf[rd_idx] : '0;
`ifdef KEY_EXPAND_ZEROIZE_EN
         if (zeroize) begin
            state      <= IDLE;
            prev       <= '0;
            rcon       <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rd_key     <= '0;
            for (int i = 0; i < NKEYS; i++) key_buf[i] <= '0;
         end else
`endif
         begin
            case (state)
               IDLE: begin
                  if (start) begin
                     key_buf[0] <= key;
                     prev       <= key;
                     rcon       <= 8'h01;
                     cnt        <= IDX_W'(1);
                     busy       <= 1'b1;
                     keys_valid <= 1'b0;
                     state      <= RUN;
                  end
               end
               RUN: begin
                  key_buf[cnt] <= next_key;
                  prev         <= next_key;
                  rcon         <= rcon_next;
                  cnt          <= cnt + IDX_W'(1);
                  if (cnt == LAST_IDX) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     keys_valid <= 1'b1;
                     cnt        <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Testbench for aes_key_expand. The expected round keys are the FIPS-197
// known-answer values. The read checks push each expected value to a queue
// when the index is driven, then pop it when rd_key updates.

module tb_aes_key_expand;

   logic         clk;
   logic         rst;
   logic [127:0] key;
   logic         start;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
`ifdef KEY_EXPAND_ZEROIZE_EN
   logic         zeroize;
`endif

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_q[$];
   logic [127:0] fips_rk [0:10];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_key_expand dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key)
`ifdef KEY_EXPAND_ZEROIZE_EN
      ,
      .zeroize    (zeroize)
`endif
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives each index in turn. The expected value is queued and then compared
   // one edge later.
   task automatic read_check(input logic [3:0] idx, input logic [127:0] exp, input string name);
      logic [127:0] e;
      rd_idx = idx;
      exp_q.push_back(exp);
      tick();
      e = exp_q.pop_front();
      total++;
      if (rd_key !== e) begin
         bad++;
         $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, rd_key, e);
      end
   endtask

   // Starts an expansion. Checks busy/keys_valid after accept and a done
   // latency of 10 cycles. Returns in the done cycle.
   task automatic run_expand(input logic [127:0] k, input string name);
      int cyc;
      bit seen;
      key   = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || keys_valid !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s_accept busy=%b kv=%b done=%b exp busy=1 kv=0 done=0",
                  name, busy, keys_valid, done);
      end
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 30) begin
         tick();
         cyc++;
         if (done === 1'b1) seen = 1;
         else begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL %s_busy cyc=%0d busy=%b exp=1", name, cyc, busy);
            end
         end
      end
      total++;
      if (!seen || cyc != 10) begin
         bad++;
         $display("FAIL %s_latency seen=%0d cycles=%0d exp=10", name, seen, cyc);
      end
      total++;
      if (busy !== 1'b0 || keys_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s_finish busy=%b kv=%b exp busy=0 kv=1", name, busy, keys_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || keys_valid !== 1'b0 || rd_key !== 128'h0) begin
         bad++;
         $display("FAIL reset busy=%b done=%b kv=%b rd_key=%h exp all 0",
                  busy, done, keys_valid, rd_key);
      end
      #2 rst = 1'b0;
      tick();
      for (int i = 0; i <= 10; i++) read_check(4'(i), 128'h0, "reset_buf");
   endtask

   task automatic test_fips();
      run_expand(FIPS_KEY, "fips");
      tick();
      total++;
      if (done !== 1'b0 || keys_valid !== 1'b1) begin
         bad++;
         $display("FAIL fips_done_width done=%b kv=%b exp done=0 kv=1", done, keys_valid);
      end
      for (int i = 0; i <= 10; i++) read_check(4'(i), fips_rk[i], "fips_rk");
   endtask

   task automatic test_out_of_range();
      read_check(4'd11, 128'h0, "oob11");
      read_check(4'd15, 128'h0, "oob15");
      read_check(4'd10, fips_rk[10], "oob_back");
   endtask

   task automatic test_read_timing();
      read_check(4'd1, fips_rk[1], "timing_a");
      rd_idx = 4'd9;
      @(negedge clk);
      total++;
      if (rd_key !== fips_rk[1]) begin
         bad++;
         $display("FAIL timing_hold got=%h exp=%h", rd_key, fips_rk[1]);
      end
      @(posedge clk);
      #1;
      total++;
      if (rd_key !== fips_rk[9]) begin
         bad++;
         $display("FAIL timing_update got=%h exp=%h", rd_key, fips_rk[9]);
      end
   endtask

   task automatic test_back_to_back();
      run_expand(128'h0, "zero");
      // Start again in the done cycle.
      run_expand(FIPS_KEY, "b2b");
      tick();
      read_check(4'd1, fips_rk[1], "b2b_rk1");
      read_check(4'd10, fips_rk[10], "b2b_rk10");
   endtask

   task automatic test_zero_key();
      run_expand(128'h0, "zero2");
      tick();
      read_check(4'd0, 128'h0, "zero_rk0");
      read_check(4'd1, ZERO_RK1, "zero_rk1");
      read_check(4'd10, ZERO_RK10, "zero_rk10");
   endtask

   task automatic test_start_while_busy();
      int cyc;
      bit seen;
      key   = FIPS_KEY;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      seen  = 0;
      while (!seen && cyc < 30) begin
         if (cyc == 4) begin
            key   = 128'hdeadbeef_00112233_44556677_8899aabb;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
         if (done === 1'b1) seen = 1;
      end
      start = 1'b0;
      total++;
      if (!seen || cyc != 10) begin
         bad++;
         $display("FAIL busy_start_latency seen=%0d cycles=%0d exp=10", seen, cyc);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_restart busy=%b exp=0", busy);
      end
      read_check(4'd0, FIPS_KEY, "busy_start_rk0");
      read_check(4'd5, fips_rk[5], "busy_start_rk5");
      read_check(4'd10, fips_rk[10], "busy_start_rk10");
   endtask

   task automatic test_reset_mid_run();
      int dones;
      key   = FIPS_KEY;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0 || keys_valid !== 1'b0 || done !== 1'b0 || rd_key !== 128'h0) begin
         bad++;
         $display("FAIL midrst busy=%b kv=%b done=%b rd_key=%h exp all 0",
                  busy, keys_valid, done, rd_key);
      end
      tick();
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL midrst_no_done dones=%0d exp=0", dones);
      end
      for (int i = 0; i <= 10; i++) read_check(4'(i), 128'h0, "midrst_buf");
      run_expand(FIPS_KEY, "midrst_fresh");
      tick();
      read_check(4'd10, fips_rk[10], "midrst_fresh_rk10");
   endtask

`ifdef KEY_EXPAND_ZEROIZE_EN
   task automatic test_zeroize();
      int dones;
      zeroize = 1'b1;
      start   = 1'b1;
      key     = FIPS_KEY;
      tick();
      zeroize = 1'b0;
      start   = 1'b0;
      total++;
      if (busy !== 1'b0 || keys_valid !== 1'b0 || rd_key !== 128'h0) begin
         bad++;
         $display("FAIL zeroize_state busy=%b kv=%b rd_key=%h exp 0", busy, keys_valid, rd_key);
      end
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL zeroize_no_run events=%0d exp=0", dones);
      end
      for (int i = 0; i <= 10; i++) read_check(4'(i), 128'h0, "zeroize_buf");
   endtask
`endif

   initial begin
      fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst    = 1'b1;
      key    = 128'h0;
      start  = 1'b0;
      rd_idx = 4'd0;
`ifdef KEY_EXPAND_ZEROIZE_EN
      zeroize = 1'b0;
`endif

      test_reset();
      test_fips();
      test_out_of_range();
      test_read_timing();
      test_back_to_back();
      test_zero_key();
      test_start_while_busy();
      test_reset_mid_run();
`ifdef KEY_EXPAND_ZEROIZE_EN
      test_zeroize();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Downstream consumer of the word-loaded key register file.
- Takes the flat 128-bit cipher key and iteratively computes the AES-128 key schedule, one round key per clock.
- Stores all 11 round keys in a local buffer; the AES round datapath reads them through an indexed, registered read port.
- Input word order: key[127:96] = w0 and key[31:0] = w3, i.e. FIPS-197 byte order with byte 0 in the MSBs.

Parameters:
- ROUNDS, 10, number of expansion rounds; the buffer holds ROUNDS+1 keys; only 10 (AES-128) is supported.
- IDX_W, 4, width of round-key index ports; must be ≥ $clog2(ROUNDS+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- key  in  128  cipher key from key store; sampled only on accepted start
- start  in  1  request expansion; accepted only when idle
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when round key ROUNDS has been written
- keys_valid  out  1  buffer holds a complete schedule for the last accepted key
- rd_idx  in  IDX_W  round-key read index
- rd_key  out  128  registered round key for rd_idx
- zeroize  in  1  present only with KEY_EXPAND_ZEROIZE_EN (see below)

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - busy=0, done=0, keys_valid=0, rd_key=0.
  - Round counter and rcon register =0; all buffer entries =0; state IDLE.
- States:
  - IDLE: on start=1 at edge E0, write buf[0]=key, load prev=key, rcon=0x01, counter=1. Go to RUN; busy=1 and keys_valid=0 from E0.
  - RUN: at each edge compute the next key from prev and write buf[counter]; update prev; advance rcon; increment counter.
  - RUN exit: at the edge writing buf[ROUNDS] (E10), go to IDLE. busy=0, done=1 for exactly one cycle, keys_valid=1 from E10.
- Round function, with prev = {p0,p1,p2,p3}:
  - t = SubWord(RotWord(p3)) ^ {rcon,24'h0}.
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
  - RotWord: left rotate by one byte.
  - SubWord: four instances of the team's combinational aes_sbox, one per byte.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. Advance is xtime: shift left, XOR 0x1B if bit 7 was set.
- Latency: start accepted → done asserted 10 cycles later. Back-to-back start is allowed in the cycle done is high, because the block is already IDLE.
- start while busy: ignored. No queuing; key changes during RUN have no effect.
- Read port:
  - rd_key <= buf[rd_idx] every edge, giving 1-cycle read latency.
  - rd_idx > ROUNDS returns 0.
  - Reads during RUN return whatever is currently stored. Consumers must gate on keys_valid.
  - A read of index k in the same cycle buf[k] is written returns the old value.
- Re-expansion overwrites entries in place. keys_valid stays low until the new schedule completes.
- Reset mid-RUN: everything returns to reset values immediately; no done pulse.

Optional Feature:
- KEY_EXPAND_ZEROIZE_EN defined:
  - zeroize port exists.
  - zeroize=1 at any edge clears all buffer entries, prev, rcon and counter; forces IDLE, busy=0, keys_valid=0; suppresses any pending done.
  - zeroize has priority over start in the same cycle; rd_key reads 0 from the next edge.
- Not defined: port absent; buffer is cleared only by rst.

Test Plan:
- FIPS-197 A.1 vector:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, start pulse at E0.
  - Response: busy high E0–E10, done high only in the cycle after E10, keys_valid=1 thereafter.
  - rd_idx=1 → a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 → the key.
- All-zero key:
  - Stimulus: key=0, start.
  - Response: rd_idx=1 → 62636363626363636263636362636363; rd_idx=10 → b4ef5bcb3e92e21123e951cf6f8f188e.
- Start while busy:
  - Stimulus: second start with a different key at E4.
  - Response: ignored; done still only after E10; schedule matches the first key.
- Reset mid-operation:
  - Stimulus: rst asserted at cycle 5 of RUN.
  - Response: busy=0, keys_valid=0, rd_key=0 on all indices, no done pulse; a fresh start then completes normally.
- Out-of-range and timing:
  - Stimulus: rd_idx=11 and 15.
  - Response: rd_key=0.
  - rd_idx changes → rd_key reflects the new index exactly one edge later.
- With KEY_EXPAND_ZEROIZE_EN:
  - Stimulus: zeroize together with start after a completed expansion.
  - Response: no expansion; keys_valid=0; all indices read 0.
